// File: rtl/mem_arbiter_if.sv
// Client and memory-controller signal bundle for the memory arbiter.
// master is the arbiter's view; slave is the surrounding environment.
interface mem_arbiter_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;

    logic        lsb_req;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_r_nw;
    logic [2:0]  lsb_type;
    logic        lsb_valid;
    logic [31:0] lsb_rdata;

    logic        flush_in;

    logic        mc_activate;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_r_nw;
    logic [2:0]  mc_type;
    logic [31:0] mc_rdata;
    logic        mc_done;

    logic        busy;

    modport master (
        input  ic_req, ic_addr,
        output ic_valid, ic_data,
        input  lsb_req, lsb_addr, lsb_wdata, lsb_r_nw, lsb_type,
        output lsb_valid, lsb_rdata,
        input  flush_in,
        output mc_activate, mc_addr, mc_wdata, mc_r_nw, mc_type,
        input  mc_rdata, mc_done,
        output busy
    );

    modport slave (
        output ic_req, ic_addr,
        input  ic_valid, ic_data,
        output lsb_req, lsb_addr, lsb_wdata, lsb_r_nw, lsb_type,
        input  lsb_valid, lsb_rdata,
        output flush_in,
        input  mc_activate, mc_addr, mc_wdata, mc_r_nw, mc_type,
        output mc_rdata, mc_done,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between icache and LSB.
// LSB has priority, bounded by a starvation counter protecting fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_IC  = 2'd1,
        ISSUE_LSB = 2'd2,
        RECOVER   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;

    logic        act_q, act_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        r_nw_q, r_nw_d;
    logic [2:0]  type_q, type_d;
    logic        ic_vld_q, ic_vld_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic        lsb_vld_q, lsb_vld_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic ic_elig, lsb_elig, gnt_ic, gnt_lsb, ic_wait;

    assign ic_wait  = bus.ic_req & ~bus.flush_in;
    assign ic_elig  = ic_wait & ~ic_vld_q;
    assign lsb_elig = bus.lsb_req & ~lsb_vld_q;
    assign gnt_ic   = ic_elig & (~lsb_elig | (cnt_q >= LIMIT));
    assign gnt_lsb  = lsb_elig & ~gnt_ic;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            act_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            r_nw_q      <= 1'b0;
            type_q      <= '0;
            ic_vld_q    <= 1'b0;
            ic_data_q   <= '0;
            lsb_vld_q   <= 1'b0;
            lsb_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            act_q       <= act_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            r_nw_q      <= r_nw_d;
            type_q      <= type_d;
            ic_vld_q    <= ic_vld_d;
            ic_data_q   <= ic_data_d;
            lsb_vld_q   <= lsb_vld_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_ic)       state_d = ISSUE_IC;
                else if (gnt_lsb) state_d = ISSUE_LSB;
            end
            ISSUE_IC,
            ISSUE_LSB: if (bus.mc_done) state_d = RECOVER;
            RECOVER:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        act_d       = act_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        r_nw_d      = r_nw_q;
        type_d      = type_q;
        ic_vld_d    = 1'b0;
        ic_data_d   = ic_data_q;
        lsb_vld_d   = 1'b0;
        lsb_rdata_d = lsb_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_ic) begin
                    act_d  = 1'b1;
                    addr_d = bus.ic_addr;
                    wdata_d = '0;
                    r_nw_d = 1'b1;
                    type_d = 3'b000;
                    cnt_d  = '0;
                end else if (gnt_lsb) begin
                    act_d   = 1'b1;
                    addr_d  = bus.lsb_addr;
                    wdata_d = bus.lsb_wdata;
                    r_nw_d  = bus.lsb_r_nw;
                    type_d  = bus.lsb_type;
                    if (!ic_wait)          cnt_d = '0;
                    else if (cnt_q < LIMIT) cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE_IC: begin
                if (bus.flush_in) discard_d = 1'b1;
                if (bus.mc_done) begin
                    act_d     = 1'b0;
                    discard_d = 1'b0;
                    // a flush landing on the done cycle also drops the word
                    if (!(discard_q | bus.flush_in)) begin
                        ic_vld_d  = 1'b1;
                        ic_data_d = bus.mc_rdata;
                    end
                end
            end
            ISSUE_LSB: begin
                if (bus.mc_done) begin
                    act_d       = 1'b0;
                    lsb_vld_d   = 1'b1;
                    lsb_rdata_d = r_nw_q ? bus.mc_rdata : 32'd0;
                end
            end
            RECOVER: act_d = 1'b0;
            default: act_d = 1'b0;
        endcase
    end

    assign bus.mc_activate = act_q;
    assign bus.mc_addr     = addr_q;
    assign bus.mc_wdata    = wdata_q;
    assign bus.mc_r_nw     = r_nw_q;
    assign bus.mc_type     = type_q;
    assign bus.ic_valid    = ic_vld_q & ~bus.flush_in;
    assign bus.ic_data     = ic_data_q;
    assign bus.lsb_valid   = lsb_vld_q;
    assign bus.lsb_rdata   = lsb_rdata_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-serial memory controller between the instruction cache (read-only word fetch) and the load/store buffer (LSB, read/write of byte, half-word or word).
- Latches the winning request and holds it stable downstream until the controller pulses done, then routes the result back to the owner.
- Priority goes to the LSB, with a starvation limit that protects instruction fetch.
- Supports a fetch flush that silently discards an in-flight icache transaction.

Parameters:
- STARVE_LIMIT, 4: number of consecutive LSB grants allowed while icache is waiting; after that, icache wins the next arbitration.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low (0 = reset)
- rdy_in  input  1  global ready; 0 freezes all state and outputs
- ic_req  input  1  icache request, level, held until ic_valid
- ic_addr  input  32  fetch address
- ic_valid  output  1  one-cycle response strobe to icache
- ic_data  output  32  fetched word, valid with ic_valid
- lsb_req  input  1  LSB request, level, held until lsb_valid
- lsb_addr  input  32  access address
- lsb_wdata  input  32  store data
- lsb_r_nw  input  1  1 = read, 0 = write
- lsb_type  input  3  [1:0] 00 word / 01 half / 10 byte; [2] 1 = unsigned
- lsb_valid  output  1  one-cycle completion strobe (loads and stores)
- lsb_rdata  output  32  load data, valid with lsb_valid
- flush_in  input  1  fetch flush (mispredict); cancels icache request/response
- mc_activate  output  1  request to memory controller
- mc_addr  output  32  latched address
- mc_wdata  output  32  latched store data
- mc_r_nw  output  1  latched direction
- mc_type  output  3  latched type
- mc_rdata  input  32  controller read data
- mc_done  input  1  controller one-cycle completion pulse
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst_in = 0, async):
  - state = IDLE, starvation counter = 0, discard flag = 0.
  - All outputs are 0, including mc_* and data outputs.
- rdy_in = 0: no state, counter, flag or output register changes; flush_in is ignored in that cycle.
- States: IDLE, ISSUE_IC, ISSUE_LSB, RECOVER.
- IDLE eligibility:
  - icache is eligible when ic_req=1, flush_in=0 and ic_valid=0.
  - LSB is eligible when lsb_req=1 and lsb_valid=0. This masks the strobe cycle so a held request is not re-granted.
- IDLE selection:
  - Only one eligible: grant it.
  - Both eligible: grant icache if counter >= STARVE_LIMIT, else grant LSB.
- On grant:
  - Register address/data/direction/type into the mc_* outputs.
  - Set mc_activate = 1 on the next cycle.
  - Go to ISSUE_IC or ISSUE_LSB.
  - Icache grants always drive mc_r_nw=1, mc_type=000, mc_wdata=0.
- Starvation counter:
  - LSB grant while ic_req=1 and not flushed: counter +1, saturating at STARVE_LIMIT.
  - Any icache grant: counter = 0.
  - LSB grant with no icache request waiting: counter = 0.
- ISSUE_x:
  - mc_* stay constant while waiting for mc_done.
  - On mc_done: mc_activate = 0 next cycle, go to RECOVER, register the response.
  - ISSUE_IC response: ic_valid = 1 and ic_data = mc_rdata next cycle, unless discard = 1; in that case no strobe and discard is cleared.
  - ISSUE_LSB response: lsb_valid = 1 next cycle; lsb_rdata = mc_rdata for loads, 0 for stores.
- RECOVER:
  - Lasts exactly one cycle with mc_activate = 0, matching the controller's post-done idle cycle.
  - Then go to IDLE.
  - Valid strobes are high during this cycle only.
- Transaction latency: grant cycle, then mc_activate high until mc_done, then RECOVER (strobe), then IDLE. Minimum request-to-next-grant gap is 2 cycles after mc_done.
- flush_in:
  - In IDLE: blocks icache eligibility that cycle.
  - In ISSUE_IC: the downstream transaction still completes (no abort); set discard = 1.
  - In RECOVER with ic_valid = 1: force ic_valid = 0 combinationally (ic_valid = registered strobe & ~flush_in).
  - No effect on LSB traffic.
- mc_done outside ISSUE_x: ignored.
- Requester drops req during ISSUE: transaction completes; strobe is still issued.
- Reset mid-transaction: state returns to IDLE immediately. The controller is reset by the same system reset event, so there is no resync requirement.

Test Plan:
- Icache only, ic_addr=0x100, mc_done 4 cycles after activate, mc_rdata=0xDEADBEEF -> mc_addr=0x100, mc_type=000, mc_r_nw=1; ic_valid one cycle with ic_data=0xDEADBEEF; no re-grant while ic_req is still held in the strobe cycle.
- ic_req and lsb_req together, LSB store addr 0x30000, wdata 0x5A, type 010 -> LSB granted first, mc_r_nw=0, lsb_valid with lsb_rdata=0; icache granted after RECOVER.
- lsb_req reasserted back-to-back 5 times with ic_req held, STARVE_LIMIT=4 -> 4 LSB grants, then icache granted, then LSB again.
- flush_in pulsed during ISSUE_IC -> mc_activate held until mc_done; no ic_valid; next LSB grant proceeds normally.
- rdy_in low for 3 cycles during ISSUE_LSB with mc_done held low -> all outputs frozen; completes normally after rdy_in returns.
- rst_in asserted low mid-ISSUE_IC -> same-cycle async clear: mc_activate=0, ic_valid=0, busy=0, counter=0.
